// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: NDIG digit codes share one segment bus, with a
// tear-free frame-boundary commit and inter-digit blanking. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits_in,
  output logic [NDIG-1:0]   an_n,
  output logic [7:0]        seg,
  output logic              busy,
  output logic              frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       pending [NDIG];
  logic [3:0]       display [NDIG];

  logic             slot_end;
  logic             frame_end;
  logic             in_blank;
  logic [3:0]       shown_code;
  logic [NDIG-1:0]  an_d;
  logic [7:0]       seg_d;

  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'd0:    s = 8'h7E;
      4'd1:    s = 8'h30;
      4'd2:    s = 8'h6D;
      4'd3:    s = 8'h79;
      4'd4:    s = 8'h33;
      4'd5:    s = 8'h5B;
      4'd6:    s = 8'h5F;
      4'd7:    s = 8'h72;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h7B;
      4'd10:   s = 8'h4F;
      4'd11:   s = 8'h01;
      4'd12,
      4'd13,
      4'd14:   s = 8'h80;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_blank  = ({1'b0, cnt} < BLANK_LIM);

  // Slot counter and digit index; idx only advances on the last cycle of a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending buffer takes every load; the display copy only moves at a frame
  // boundary, so a load on that same cycle stays pending for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        pending[i] <= 4'd15;
        display[i] <= 4'd15;
      end
    end else begin
      if (frame_end && busy) begin
        for (int i = 0; i < NDIG; i++) display[i] <= pending[i];
      end
      if (load) begin
        busy <= 1'b1;
        for (int i = 0; i < NDIG; i++) pending[i] <= digits_in[4*i +: 4];
      end else if (frame_end) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NDIG-1:0] lz_blank;

  // A zero is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    for (int i = 1; i < NDIG; i++) begin
      lz_blank[i] = 1'b1;
      for (int j = i; j < NDIG; j++) begin
        if (display[j] != 4'd0) lz_blank[i] = 1'b0;
      end
    end
  end

  assign shown_code = lz_blank[idx] ? 4'd15 : display[idx];
`else
  assign shown_code = display[idx];
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 8'h00;
    if (!in_blank) begin
      for (int i = 0; i < NDIG; i++) an_d[i] = (idx != IDX_W'(i));
      seg_d = seg_decode(shown_code);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n       <= '1;
      seg        <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_d;
      seg        <= seg_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (NDIG=4, REFRESH_DIV=8, BLANK_CYC=2): decode table vectors,
// commit/reset corner sequences and random loads against a cycle-indexed reference model.
module tb_seg7_scan_driver;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  an_n;
  logic [7:0]  seg;
  logic        busy;
  logic        frame_tick;

  seg7_scan_driver #(.NDIG(NDIG), .REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .an_n       (an_n),
    .seg        (seg),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  // Reference model: c is the number of cycles since reset release.
  int         c;
  logic [3:0] m_disp [NDIG];
  logic [3:0] m_pend [NDIG];
  logic       m_busy;
  logic [7:0] seg_tab [16];

  typedef struct {
    logic [15:0] digits;
    logic [31:0] exp_segs;   // {slot3, slot2, slot1, slot0}
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int ix);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = ix; j < NDIG; j++) if (m_disp[j] != 4'd0) all_zero = 1'b0;
`ifdef SEG7_LZB_EN
    if (ix > 0 && all_zero) return 8'h00;
`endif
    return seg_tab[m_disp[ix]];
  endfunction

  task automatic model_reset();
    c      = 0;
    m_busy = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      m_disp[i] = 4'd15;
      m_pend[i] = 4'd15;
    end
  endtask

  // One clock: drive inputs, predict from the cycle number, compare 1 time unit after the edge.
  task automatic step(input logic ld, input logic [15:0] d);
    int         cn;
    int         ix;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_tick;
    load      = ld;
    digits_in = d;
    @(posedge clk);
    cn       = c % DIV;
    ix       = (c / DIV) % NDIG;
    exp_an   = 4'hF;
    exp_seg  = 8'h00;
    if (cn >= BLANK) begin
      exp_an[ix] = 1'b0;
      exp_seg    = model_seg(ix);
    end
    exp_tick = ((c % FRAME) == FRAME - 1);
    if (exp_tick && m_busy) begin
      for (int i = 0; i < NDIG; i++) m_disp[i] = m_pend[i];
      m_busy = 1'b0;
    end
    if (ld) begin
      for (int i = 0; i < NDIG; i++) m_pend[i] = d[4*i +: 4];
      m_busy = 1'b1;
    end
    c++;
    #1;
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    load = 1'b0;
  endtask

  task automatic run_to(input int pos);
    for (int k = 0; k < FRAME && (c % FRAME) != pos; k++) step(1'b0, 16'h0000);
  endtask

  initial begin
    logic [31:0] ev;
    seg_tab = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h72,
                8'h7F, 8'h7B, 8'h4F, 8'h01, 8'h80, 8'h80, 8'h80, 8'h00};
    vecs[0] = '{16'h1234, 32'h306D7933};
    vecs[1] = '{16'h5678, 32'h5B5F727F};
    vecs[2] = '{16'h9ABC, 32'h7B4F0180};
    vecs[3] = '{16'hDEF0, 32'h8080007E};
    vecs[4] = '{16'h1034, 32'h307E7933};
`ifdef SEG7_LZB_EN
    vecs[5] = '{16'h0070, 32'h0000727E};
    vecs[6] = '{16'h0000, 32'h0000007E};
`else
    vecs[5] = '{16'h0070, 32'h7E7E727E};
    vecs[6] = '{16'h0000, 32'h7E7E7E7E};
`endif

    reset     = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an_n", 32'(an_n), 32'hF);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Idle frames: blank codes, scan pattern and frame_tick cadence.
    for (int k = 0; k < 2 * FRAME; k++) step(1'b0, 16'h0000);

    // Table vectors: load mid-frame, then sample each slot of the next frame.
    foreach (vecs[v]) begin
      run_to(5);
      step(1'b1, vecs[v].digits);
      chk("busy_after_load", 32'(busy), 32'h1);
      run_to(0);
      ev = vecs[v].exp_segs;
      for (int s = 0; s < NDIG; s++) begin
        run_to(s * DIV + 5);
        chk("table_seg", 32'(seg), 32'(ev[s*8 +: 8]));
      end
    end

    // Two loads in one frame: only the last is shown.
    run_to(3);
    step(1'b1, 16'h1111);
    run_to(10);
    step(1'b1, 16'h9876);
    run_to(0);
    run_to(4);
    chk("last_load_slot0", 32'(seg), 32'h5F);
    run_to(28);
    chk("last_load_slot3", 32'(seg), 32'h7B);

    // Load exactly on the commit cycle.
    run_to(8);
    step(1'b1, 16'h2222);
    run_to(FRAME - 1);
    step(1'b1, 16'h5555);
    chk("commit_load_busy", 32'(busy), 32'h1);
    run_to(4);
    chk("commit_old_shown", 32'(seg), 32'h6D);
    chk("commit_busy_between", 32'(busy), 32'h1);
    run_to(0);
    run_to(4);
    chk("commit_new_shown", 32'(seg), 32'h5B);

    // Asynchronous reset mid-slot with data pending.
    run_to(2 * DIV);
    step(1'b1, 16'h4321);
    run_to(2 * DIV + 5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_an_n", 32'(an_n), 32'hF);
    chk("async_seg", 32'(seg), 32'h00);
    chk("async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random loads over several frames against the model.
    for (int k = 0; k < 8 * FRAME; k++) begin
      if ($urandom_range(0, 9) == 0) step(1'b1, 16'($urandom));
      else                           step(1'b0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
